elevator_car: RTL and testbench
===============================

Name: elevator_car

Overview:
- Synthesizable car/plant model that answers the elevator command interface: takes `door_open` and `updown` commands and returns `door` status and the current `floor`.
- It is the responder end of the link driven by the target-floor controller.
- Replaces delay-based behaviour with clocked travel and door timers so the controller stack can be simulated cycle-accurately and synthesized.
- Also flags illegal commands.

Parameters:
- NUM_FLOORS, 8, number of floors; floors are numbered 0..NUM_FLOORS-1.
- FLOOR_WIDTH, 3, width of `floor`; must satisfy 2^FLOOR_WIDTH >= NUM_FLOORS.
- TRAVEL_CYCLES, 10, clock cycles to travel one floor; must be >= 2.
- DOOR_CYCLES, 5, clock cycles to fully open or fully close the door; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- door_open  input  1  level request: 1 = open or hold open the door, 0 = close it.
- updown  input  2  motion command: 00 = stop, 01 = up, 10 = down, 11 = illegal.
- door  output  1  1 only while the door is fully open (state OPEN).
- floor  output  FLOOR_WIDTH  current floor (last floor reached).
- moving  output  1  1 in MOVE_UP or MOVE_DOWN.
- arrived  output  1  one-cycle pulse in the cycle `floor` updates.
- cmd_error  output  1  registered; high the cycle after an illegal command is sampled.

Behaviour:
- Reset (sampled on `clk` with `rst` = 1): state IDLE, `floor` = 0, `door` = 0, `moving` = 0, `arrived` = 0, `cmd_error` = 0, timer = 0. Reset mid-travel or mid-door-motion aborts immediately. No partial floor is retained.
- All outputs are registered.
- Timer width is clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)).
- States: IDLE (door closed, stopped), OPENING, OPEN, CLOSING, MOVE_UP, MOVE_DOWN.
- IDLE:
  - `door_open` = 1 -> OPENING with timer = 0. Door takes priority over a simultaneous `updown` move request; that move request is not an error.
  - Else `updown` = 01 and `floor` < NUM_FLOORS-1 -> MOVE_UP with timer = 0.
  - Else `updown` = 10 and `floor` > 0 -> MOVE_DOWN with timer = 0.
  - `updown` = 01 at the top floor, or 10 at floor 0 -> stay in IDLE, set `cmd_error`.
- OPENING:
  - Timer increments each cycle. At timer == DOOR_CYCLES-1 -> OPEN; `door` = 1 from the first OPEN cycle.
  - If `door_open` drops during OPENING, finish opening, then close from OPEN.
- OPEN: `door_open` = 0 -> CLOSING with timer = 0; `door` = 0 in the same register update.
- CLOSING:
  - At timer == DOOR_CYCLES-1 -> IDLE.
  - If `door_open` = 1 during CLOSING -> re-open: go to OPENING with timer = 0.
- MOVE_UP / MOVE_DOWN:
  - Timer increments each cycle.
  - At timer == TRAVEL_CYCLES-1: `floor` becomes `floor` ± 1, `arrived` = 1 for that cycle, timer = 0.
  - After that update, if `updown` still commands the same direction and the new floor is not the end floor in that direction, continue moving. Otherwise -> IDLE.
  - A stop (00) or reverse command mid-floor does not abort the move: the car always completes to the next floor. A reverse command is then serviced from IDLE on a later cycle.
- Illegal commands set `cmd_error` for one cycle per sampled cycle. State is unchanged unless stated otherwise. Illegal commands are:
  - `updown` = 11 in any state.
  - `updown` = 01 or 10 while in OPENING, OPEN or CLOSING.
  - `door_open` = 1 while moving; this is ignored and the door stays closed.
  - The end-of-shaft requests in IDLE listed above.
- Invariant: `door` = 1 implies `moving` = 0, and `floor` stays within 0..NUM_FLOORS-1 at all times.
- `floor` changes by at most 1 per TRAVEL_CYCLES cycles. There is no wrap-around at the top or bottom floor.

Test Plan:
- Reset, then `updown` = 01 held 25 cycles, then 00 -> `moving` = 1; `floor` = 1 after cycle 10 and 2 after cycle 20 (each with an `arrived` pulse); `floor` = 3 after cycle 30 (completes despite the stop); `moving` = 0; `cmd_error` never asserted.
- At floor 0 in IDLE, `door_open` = 1 held -> `door` = 1 after 5 cycles. Drop `door_open` -> `door` = 0 next cycle; IDLE 5 cycles later.
- During CLOSING at timer = 2, reassert `door_open` -> back to OPENING; `door` = 1 exactly 5 cycles later.
- `door_open` = 1 and `updown` = 01 in the same IDLE cycle -> door opens, car does not move, `cmd_error` = 0. Keep `updown` = 01 while OPEN -> `cmd_error` = 1 each cycle; `floor` unchanged.
- At floor 7 (NUM_FLOORS = 8), `updown` = 01 -> `cmd_error` pulse, stays at 7. At floor 0, `updown` = 10 -> same. `updown` = 11 -> `cmd_error`, no motion.
- Assert `rst` at timer = 6 of MOVE_UP from floor 4 -> next cycle `floor` = 0, `moving` = 0, `door` = 0, `arrived` = 0.

Source files
------------

// File: rtl/elevator_car.sv
// Cycle-accurate elevator car/plant model: travels floor by floor on clocked timers,
// opens and closes its door on command, and flags commands it cannot honour.
module elevator_car #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_WIDTH   = 3,
    parameter int unsigned TRAVEL_CYCLES = 10,
    parameter int unsigned DOOR_CYCLES   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   door_open,
    input  logic [1:0]             updown,
    output logic                   door,
    output logic [FLOOR_WIDTH-1:0] floor,
    output logic                   moving,
    output logic                   arrived,
    output logic                   cmd_error
);

    localparam int unsigned MaxCycles  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                       : DOOR_CYCLES;
    localparam int unsigned TimerWidth = $clog2(MaxCycles);

    localparam logic [TimerWidth-1:0]  TravelLast = TimerWidth'(TRAVEL_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  DoorLast   = TimerWidth'(DOOR_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  TimerOne   = TimerWidth'(1);
    localparam logic [FLOOR_WIDTH-1:0] TopFloor   = FLOOR_WIDTH'(NUM_FLOORS - 1);
    localparam logic [FLOOR_WIDTH-1:0] FloorOne   = FLOOR_WIDTH'(1);

    localparam logic [1:0] CmdUp      = 2'b01;
    localparam logic [1:0] CmdDown    = 2'b10;
    localparam logic [1:0] CmdIllegal = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StOpening,
        StOpen,
        StClosing,
        StMoveUp,
        StMoveDown
    } state_e;

    state_e                 state_q, state_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
    logic                   door_q, door_d;
    logic                   moving_q, moving_d;
    logic                   arrived_q, arrived_d;
    logic                   cmd_error_q, cmd_error_d;

    logic cmd_up, cmd_down;
    assign cmd_up   = (updown == CmdUp);
    assign cmd_down = (updown == CmdDown);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            floor_q     <= '0;
            door_q      <= 1'b0;
            moving_q    <= 1'b0;
            arrived_q   <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            floor_q     <= floor_d;
            door_q      <= door_d;
            moving_q    <= moving_d;
            arrived_q   <= arrived_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        floor_d   = floor_q;
        arrived_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (door_open) begin
                    state_d = StOpening;
                end else if (cmd_up && floor_q != TopFloor) begin
                    state_d = StMoveUp;
                end else if (cmd_down && floor_q != '0) begin
                    state_d = StMoveDown;
                end
            end
            StOpening: begin
                // Opening always completes; a dropped request is handled from StOpen.
                if (timer_q == DoorLast) begin
                    state_d = StOpen;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StOpen: begin
                timer_d = '0;
                if (!door_open) begin
                    state_d = StClosing;
                end
            end
            StClosing: begin
                if (door_open) begin
                    state_d = StOpening;
                    timer_d = '0;
                end else if (timer_q == DoorLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StMoveUp: begin
                if (timer_q == TravelLast) begin
                    floor_d   = floor_q + FloorOne;
                    arrived_d = 1'b1;
                    timer_d   = '0;
                    state_d   = (cmd_up && floor_d != TopFloor) ? StMoveUp : StIdle;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StMoveDown: begin
                if (timer_q == TravelLast) begin
                    floor_d   = floor_q - FloorOne;
                    arrived_d = 1'b1;
                    timer_d   = '0;
                    state_d   = (cmd_down && floor_d != '0) ? StMoveDown : StIdle;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        door_d      = (state_d == StOpen);
        moving_d    = (state_d == StMoveUp) || (state_d == StMoveDown);
        cmd_error_d = (updown == CmdIllegal);
        unique case (state_q)
            StIdle: begin
                // A simultaneous door request wins, so the move is not an error then.
                if (!door_open && ((cmd_up && floor_q == TopFloor) ||
                                   (cmd_down && floor_q == '0))) begin
                    cmd_error_d = 1'b1;
                end
            end
            StOpening, StOpen, StClosing: begin
                if (cmd_up || cmd_down) begin
                    cmd_error_d = 1'b1;
                end
            end
            StMoveUp, StMoveDown: begin
                if (door_open) begin
                    cmd_error_d = 1'b1;
                end
            end
            default: begin
                cmd_error_d = 1'b1;
            end
        endcase
    end

    assign door      = door_q;
    assign floor     = floor_q;
    assign moving    = moving_q;
    assign arrived   = arrived_q;
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_elevator_car.sv
// Directed bench for elevator_car: stimulus queues expected output snapshots tagged with
// the clock edge they apply to; a monitor checks each snapshot when that edge has passed.
module tb_elevator_car;

    logic       clk;
    logic       rst;
    logic       door_open;
    logic [1:0] updown;
    logic       door;
    logic [2:0] floor;
    logic       moving;
    logic       arrived;
    logic       cmd_error;

    elevator_car #(
        .NUM_FLOORS   (8),
        .FLOOR_WIDTH  (3),
        .TRAVEL_CYCLES(10),
        .DOOR_CYCLES  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .door_open(door_open),
        .updown   (updown),
        .door     (door),
        .floor    (floor),
        .moving   (moving),
        .arrived  (arrived),
        .cmd_error(cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       door;
        logic [2:0] floor;
        logic       moving;
        logic       arrived;
        logic       err;
    } outs_t;

    int    edge_cnt = 0;
    int    total    = 0;
    int    bad      = 0;
    int    next_tag = 0;
    int    cyc_q[$];
    int    tag_q[$];
    outs_t exp_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // d = 1 means "after the next rising edge, which samples the inputs driven now".
    task automatic exp_at(input int d, input logic dr, input int fl, input logic mv,
                          input logic ar, input logic er);
        outs_t e;
        e.door    = dr;
        e.floor   = 3'(fl);
        e.moving  = mv;
        e.arrived = ar;
        e.err     = er;
        cyc_q.push_back(edge_cnt + d);
        tag_q.push_back(next_tag);
        exp_q.push_back(e);
        next_tag++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        door_open = 1'b0;
        updown    = 2'b00;
        exp_at(1, 0, 0, 0, 0, 0);
        tick(1);
        rst = 1'b0;
    endtask

    // Monitor: compare every snapshot whose edge has arrived; late ones count as failures.
    always @(negedge clk) begin
        int    i;
        outs_t act;
        act = {door, floor, moving, arrived, cmd_error};
        i   = 0;
        while (i < cyc_q.size()) begin
            if (cyc_q[i] <= edge_cnt) begin
                total++;
                if (cyc_q[i] != edge_cnt || act !== exp_q[i]) begin
                    bad++;
                    $display("FAIL chk%0d edge%0d: got door=%0b floor=%0d moving=%0b arrived=%0b err=%0b, want door=%0b floor=%0d moving=%0b arrived=%0b err=%0b (due edge%0d)",
                             tag_q[i], edge_cnt, act.door, act.floor, act.moving,
                             act.arrived, act.err, exp_q[i].door, exp_q[i].floor,
                             exp_q[i].moving, exp_q[i].arrived, exp_q[i].err, cyc_q[i]);
                end
                cyc_q.delete(i);
                tag_q.delete(i);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        if (!rst && edge_cnt > 2) begin
            total++;
            if (door === 1'b1 && moving !== 1'b0) begin
                bad++;
                $display("FAIL door_vs_moving edge%0d: got door=1 moving=%0b, want moving=0",
                         edge_cnt, moving);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        door_open = 1'b0;
        updown    = 2'b00;
        tick(2);
        do_reset();

        // Climb with up held 25 cycles then stop: the third floor still completes.
        for (int d = 1; d <= 32; d++) begin
            exp_at(d, 0, (d >= 31) ? 3 : (d >= 21) ? 2 : (d >= 11) ? 1 : 0,
                   (d <= 30), (d == 11 || d == 21 || d == 31), 0);
        end
        updown = 2'b01;
        tick(25);
        updown = 2'b00;
        tick(7);

        // Open, hold, close; an up request during the last closing cycle is an error,
        // one cycle later the car is idle and the same request starts a move.
        do_reset();
        for (int d = 1; d <= 15; d++) begin
            exp_at(d, (d >= 6 && d <= 8), 0, (d == 15), 0, (d == 14));
        end
        door_open = 1'b1;
        tick(8);
        door_open = 1'b0;
        tick(5);
        updown = 2'b01;
        tick(2);

        // Re-open from closing at timer 2.
        do_reset();
        for (int d = 1; d <= 18; d++) begin
            exp_at(d, (d >= 6 && d <= 8) || (d >= 17), 0, 0, 0, 0);
        end
        door_open = 1'b1;
        tick(8);
        door_open = 1'b0;
        tick(3);
        door_open = 1'b1;
        tick(7);

        // Door request and up together: door wins, then up is illegal while door active.
        do_reset();
        for (int d = 1; d <= 9; d++) begin
            exp_at(d, (d >= 6), 0, 0, 0, (d >= 2 && d <= 8));
        end
        door_open = 1'b1;
        updown    = 2'b01;
        tick(8);
        updown = 2'b00;
        tick(1);

        // Shaft ends and the 11 code, then climb to the top floor and push past it.
        do_reset();
        exp_at(1, 0, 0, 0, 0, 1);
        exp_at(2, 0, 0, 0, 0, 1);
        exp_at(3, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            exp_at(3 + 10 * k, 0, k - 1, 1, 0, 0);
            exp_at(4 + 10 * k, 0, k, (k < 7), 1, 0);
        end
        exp_at(75, 0, 7, 0, 0, 1);
        exp_at(76, 0, 7, 0, 0, 1);
        exp_at(77, 0, 7, 0, 0, 0);
        exp_at(78, 0, 7, 0, 0, 1);
        updown = 2'b10;
        tick(1);
        updown = 2'b11;
        tick(1);
        updown = 2'b00;
        tick(1);
        updown = 2'b01;
        tick(73);
        updown = 2'b00;
        tick(1);
        updown = 2'b11;
        tick(1);
        updown = 2'b00;

        // Door request while moving is refused; reset at timer 6 above floor 4 aborts.
        do_reset();
        exp_at(41, 0, 4, 1, 1, 0);
        exp_at(43, 0, 4, 1, 0, 1);
        exp_at(44, 0, 4, 1, 0, 1);
        exp_at(45, 0, 4, 1, 0, 0);
        exp_at(47, 0, 4, 1, 0, 0);
        exp_at(48, 0, 0, 0, 0, 0);
        exp_at(49, 0, 0, 0, 0, 0);
        updown = 2'b01;
        tick(42);
        door_open = 1'b1;
        tick(2);
        door_open = 1'b0;
        tick(3);
        rst    = 1'b1;
        updown = 2'b00;
        tick(1);
        rst = 1'b0;
        tick(1);

        for (int w = 0; w < 10 && cyc_q.size() != 0; w++) tick(1);
        while (cyc_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL chk%0d never checked: got no sample, want edge%0d",
                     tag_q[0], cyc_q[0]);
            cyc_q.delete(0);
            tag_q.delete(0);
            exp_q.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
